koa_mul_arbiter: RTL

KOA_MUL_ARBITER -- requirements
Module: koa_mul_arbiter

---
 rtl/koa_mul_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/koa_mul_arbiter.sv
// Two-requester arbiter around a multicycle Karatsuba multiplier core.
// Define KOA_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module koa_mul_arbiter #(
    parameter int SW        = 54,
    parameter int precision = 1,
    parameter int SETTLE    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_i,
    input  logic [SW-1:0]   a0_i,
    input  logic [SW-1:0]   b0_i,
    input  logic            req1_i,
    input  logic [SW-1:0]   a1_i,
    input  logic [SW-1:0]   b1_i,
    output logic            gnt0_o,
    output logic            gnt1_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic            id_o,
    output logic [2*SW-1:0] result_o,
    input  logic            ready_i
);
    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    state_t          state_d;
    logic [SW-1:0]   opa;
    logic [SW-1:0]   opb;
    logic [CW-1:0]   cnt;
    logic [2*SW-1:0] prod;
    logic            grant;
    logic            pick1;

`ifdef KOA_ARB_RR_EN
    logic last;

    // last == 1 means requester 1 was served most recently
    assign pick1 = req1_i & (~req0_i | ~last);

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (grant) begin
            last <= pick1;
        end
    end
`else
    assign pick1 = req1_i & ~req0_i;
`endif

    assign grant   = (state == IDLE) & ~rst & (req0_i | req1_i);
    assign gnt0_o  = grant & ~pick1;
    assign gnt1_o  = grant & pick1;
    assign busy_o  = (state != IDLE);
    assign valid_o = (state == DONE);

    KOA_c #(
        .SW       (SW),
        .precision(precision)
    ) u_koa (
        .Data_A_i    (opa),
        .Data_B_i    (opb),
        .sgf_result_o(prod)
    );

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (grant) state_d = CALC;
            CALC:    if (cnt == '0) state_d = DONE;
            DONE:    if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Core is combinational; cnt gives it SETTLE cycles before result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            opa      <= '0;
            opb      <= '0;
            id_o     <= 1'b0;
            cnt      <= '0;
            result_o <= '0;
        end else begin
            if (grant) begin
                opa  <= pick1 ? a1_i : a0_i;
                opb  <= pick1 ? b1_i : b0_i;
                id_o <= pick1;
                cnt  <= CW'(SETTLE - 1);
            end
            if (state == CALC) begin
                if (cnt == '0) begin
                    result_o <= prod;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end
endmodule

// One-level Karatsuba split, falling back to a direct product for narrow operands.
module KOA_c #(
    parameter int SW        = 54,
    parameter int precision = 1
) (
    input  logic [SW-1:0]   Data_A_i,
    input  logic [SW-1:0]   Data_B_i,
    output logic [2*SW-1:0] sgf_result_o
);
    localparam int L = SW / 2;

    generate
        if (SW <= 2 * precision + 1) begin : g_base
            logic [2*SW-1:0] ea;
            logic [2*SW-1:0] eb;
            assign ea           = {{SW{1'b0}}, Data_A_i};
            assign eb           = {{SW{1'b0}}, Data_B_i};
            assign sgf_result_o = ea * eb;
        end else begin : g_split
            logic [2*SW-1:0] ah, al, bh, bl;
            logic [2*SW-1:0] sa, sb, z0, z1, z2;
            assign ah = {{(SW+L){1'b0}}, Data_A_i[SW-1:L]};
            assign al = {{(2*SW-L){1'b0}}, Data_A_i[L-1:0]};
            assign bh = {{(SW+L){1'b0}}, Data_B_i[SW-1:L]};
            assign bl = {{(2*SW-L){1'b0}}, Data_B_i[L-1:0]};
            assign z2 = ah * bh;
            assign z0 = al * bl;
            assign sa = ah + al;
            assign sb = bh + bl;
            assign z1 = sa * sb - z2 - z0;
            assign sgf_result_o = (z2 << (2 * L)) + (z1 << L) + z0;
        end
    endgenerate
endmodule
